// File: rtl/lc3_mem_if.sv
// lc3_mem_if: LC-3 memory/I-O access stage.
// Sequences a fixed-latency synchronous SRAM with WAIT_CYCLES wait states and
// decodes the memory-mapped keyboard/display registers in xFE00-xFFFF.
// Produces the keyboard interrupt request for the control FSM.
// Optional build macro: LC3_DISP_INT_EN adds a writable display IE bit (DSR[14])
// and a display interrupt source (vector 8'h81, priority 3'd4).

module lc3_mem_if #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [7:0]  KB_VECTOR   = 8'h80,
  parameter logic [2:0]  KB_PRIORITY = 3'd4
) (
  input  logic        clk,
  input  logic        rst,
  // Control/datapath side
  input  logic        memEN,
  input  logic        memWE,
  input  logic [15:0] mar,
  input  logic [15:0] mdr_out,
  output logic [15:0] rd_data,
  output logic        memRDY,
  // SRAM side
  output logic        sram_ce,
  output logic        sram_we,
  output logic [15:0] sram_addr,
  output logic [15:0] sram_wdata,
  input  logic [15:0] sram_rdata,
  // Keyboard
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  // Display
  output logic        disp_valid,
  output logic [7:0]  disp_data,
  input  logic        disp_ack,
  // Interrupt request
  output logic        INT,
  output logic [7:0]  int_vector,
  output logic [2:0]  int_priority
);

  localparam logic [15:0] AddrKbsr = 16'hFE00;
  localparam logic [15:0] AddrKbdr = 16'hFE02;
  localparam logic [15:0] AddrDsr  = 16'hFE04;
  localparam logic [15:0] AddrDdr  = 16'hFE06;

  // Counter preload: SWAIT lasts WAIT_CYCLES cycles (WAIT_CYCLES-1 down to 0).
  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES - 1);

  localparam logic [7:0] DispVector   = 8'h81;
  localparam logic [2:0] DispPriority = 3'd4;

  typedef enum logic [1:0] {
    StIdle,
    StSwait,
    StMmio,
    StDone
  } state_e;

  state_e      state_q;
  logic [3:0]  wait_cnt_q;
  logic        req_we_q;

  logic        kb_ready_q;
  logic        kb_ie_q;
  logic [7:0]  kbdr_q;
  logic        dsr_ie;

  logic        mmio_cycle;
  logic        kbsr_wr;
  logic        kbdr_rd;
  logic        dsr_wr;
  logic        ddr_wr;
  logic [15:0] mmio_rdata;
  logic        kb_int;
  logic        disp_int;

  // The latched request lives in sram_addr/sram_wdata; MMIO accesses reuse them
  // but never pulse sram_ce, so the SRAM ignores those values.
  always_comb begin
    mmio_cycle = (state_q == StMmio);
    kbsr_wr    = mmio_cycle &&  req_we_q && (sram_addr == AddrKbsr);
    kbdr_rd    = mmio_cycle && !req_we_q && (sram_addr == AddrKbdr);
    dsr_wr     = mmio_cycle &&  req_we_q && (sram_addr == AddrDsr);
    ddr_wr     = mmio_cycle &&  req_we_q && (sram_addr == AddrDdr);
  end

  // Register read mux; unmapped MMIO addresses read as zero.
  always_comb begin
    mmio_rdata = '0;
    case (sram_addr)
      AddrKbsr: mmio_rdata = {kb_ready_q, kb_ie_q, 14'h0000};
      AddrKbdr: mmio_rdata = {8'h00, kbdr_q};
      AddrDsr:  mmio_rdata = {~disp_valid, dsr_ie, 14'h0000};
      AddrDdr:  mmio_rdata = {8'h00, disp_data};
      default:  mmio_rdata = '0;
    endcase
  end

  // Access sequencer: IDLE -> (SWAIT | MMIO) -> DONE -> IDLE, outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      req_we_q   <= 1'b0;
      sram_ce    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      rd_data    <= '0;
      memRDY     <= 1'b0;
    end else begin
      sram_ce <= 1'b0;
      sram_we <= 1'b0;
      memRDY  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (memEN) begin
            sram_addr  <= mar;
            sram_wdata <= mdr_out;
            req_we_q   <= memWE;
            if (mar[15:9] == 7'h7F) begin
              state_q <= StMmio;
            end else begin
              sram_ce    <= 1'b1;
              sram_we    <= memWE;
              wait_cnt_q <= WaitInit;
              state_q    <= StSwait;
            end
          end
        end
        StSwait: begin
          if (wait_cnt_q == 4'd0) begin
            if (!req_we_q) begin
              rd_data <= sram_rdata;
            end
            memRDY  <= 1'b1;
            state_q <= StDone;
          end else begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
          end
        end
        StMmio: begin
          if (!req_we_q) begin
            rd_data <= mmio_rdata;
          end
          memRDY  <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Keyboard: a strobe loads KBDR when empty, or when the same cycle's KBDR read
  // frees it (the read still returns the old byte via mmio_rdata).
  always_ff @(posedge clk) begin
    if (rst) begin
      kb_ready_q <= 1'b0;
      kb_ie_q    <= 1'b0;
      kbdr_q     <= '0;
    end else begin
      if (kb_valid && (!kb_ready_q || kbdr_rd)) begin
        kbdr_q     <= kb_data;
        kb_ready_q <= 1'b1;
      end else if (kbdr_rd) begin
        kb_ready_q <= 1'b0;
      end
      if (kbsr_wr) begin
        kb_ie_q <= sram_wdata[14];
      end
    end
  end

  // Display: a DDR write is taken when the slot is free or being acked this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_valid <= 1'b0;
      disp_data  <= '0;
    end else begin
      if (ddr_wr && (!disp_valid || disp_ack)) begin
        disp_data  <= sram_wdata[7:0];
        disp_valid <= 1'b1;
      end else if (disp_ack) begin
        disp_valid <= 1'b0;
      end
    end
  end

`ifdef LC3_DISP_INT_EN
  logic dsr_ie_q;

  // Display interrupt enable, written through DSR bit 14.
  always_ff @(posedge clk) begin
    if (rst) begin
      dsr_ie_q <= 1'b0;
    end else if (dsr_wr) begin
      dsr_ie_q <= sram_wdata[14];
    end
  end

  assign dsr_ie   = dsr_ie_q;
  assign disp_int = ~disp_valid & dsr_ie_q;
`else
  // No display interrupt source: DSR bit 14 is hardwired low.
  logic unused_dsr_wr;
  assign unused_dsr_wr = dsr_wr;
  assign dsr_ie        = 1'b0;
  assign disp_int      = 1'b0;
`endif

  assign kb_int = kb_ready_q & kb_ie_q;

  // Interrupt request; keyboard wins when both sources are pending.
  always_comb begin
    INT          = kb_int | disp_int;
    int_vector   = '0;
    int_priority = '0;
    if (kb_int) begin
      int_vector   = KB_VECTOR;
      int_priority = KB_PRIORITY;
    end else if (disp_int) begin
      int_vector   = DispVector;
      int_priority = DispPriority;
    end
  end

endmodule

// File: tb/tb_lc3_mem_if.sv
// Directed testbench for lc3_mem_if (WAIT_CYCLES = 2).

module tb_lc3_mem_if;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memEN = 1'b0;
  logic        memWE = 1'b0;
  logic [15:0] mar = '0;
  logic [15:0] mdr_out = '0;
  logic [15:0] rd_data;
  logic        memRDY;
  logic        sram_ce;
  logic        sram_we;
  logic [15:0] sram_addr;
  logic [15:0] sram_wdata;
  logic [15:0] sram_rdata;
  logic        kb_valid = 1'b0;
  logic [7:0]  kb_data = '0;
  logic        disp_valid;
  logic [7:0]  disp_data;
  logic        disp_ack = 1'b0;
  logic        INT;
  logic [7:0]  int_vector;
  logic [2:0]  int_priority;

  int tests_run = 0;
  int tests_failed = 0;

  lc3_mem_if #(
    .WAIT_CYCLES(2),
    .KB_VECTOR  (8'h80),
    .KB_PRIORITY(3'd4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .memEN       (memEN),
    .memWE       (memWE),
    .mar         (mar),
    .mdr_out     (mdr_out),
    .rd_data     (rd_data),
    .memRDY      (memRDY),
    .sram_ce     (sram_ce),
    .sram_we     (sram_we),
    .sram_addr   (sram_addr),
    .sram_wdata  (sram_wdata),
    .sram_rdata  (sram_rdata),
    .kb_valid    (kb_valid),
    .kb_data     (kb_data),
    .disp_valid  (disp_valid),
    .disp_data   (disp_data),
    .disp_ack    (disp_ack),
    .INT         (INT),
    .int_vector  (int_vector),
    .int_priority(int_priority)
  );

  always #5 clk = ~clk;

  // SRAM model: write on a ce+we edge, read data follows the held address.
  logic [15:0] sram_mem [0:65535];
  assign sram_rdata = sram_mem[sram_addr];
  always @(posedge clk) begin
    if (sram_ce && sram_we) sram_mem[sram_addr] <= sram_wdata;
  end

  // One access; pulse 1 = kb_valid, 2 = disp_ack during the cycle after the request.
  task automatic mem_access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                            input int pulse, input logic [7:0] pbyte,
                            output logic [15:0] rdata, output int lat, output int ces,
                            output logic we_seen);
    @(negedge clk);
    memEN = 1'b1; memWE = we; mar = addr; mdr_out = wdata;
    lat = -1; ces = 0; we_seen = 1'b0; rdata = '0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      kb_valid = 1'b0; disp_ack = 1'b0;
      if (i == 1 && pulse == 1) begin kb_valid = 1'b1; kb_data = pbyte; end
      if (i == 1 && pulse == 2) disp_ack = 1'b1;
      if (sram_ce) begin ces++; we_seen = sram_we; end
      if (memRDY) begin lat = i; rdata = rd_data; break; end
    end
    memEN = 1'b0; memWE = 1'b0; kb_valid = 1'b0; disp_ack = 1'b0;
    @(posedge clk); #1;
    if (sram_ce) ces++;
  endtask

  task automatic kb_strobe(input logic [7:0] b);
    @(negedge clk); kb_valid = 1'b1; kb_data = b;
    @(negedge clk); kb_valid = 1'b0;
  endtask

  task automatic ack_pulse();
    @(negedge clk); disp_ack = 1'b1;
    @(negedge clk); disp_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [71:0] outs;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    outs = {rd_data, memRDY, sram_ce, sram_we, sram_addr, sram_wdata, disp_valid, disp_data,
            INT, int_vector, int_priority};
    tests_run++;
    if (outs !== '0) begin
      tests_failed++; $display("FAIL reset_outputs: got %h want 0", outs);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if ({memRDY, sram_ce} !== 2'b00) begin
      tests_failed++; $display("FAIL idle_after_reset: got %b want 00", {memRDY, sram_ce});
    end
  endtask

  task automatic test_sram_rw();
    logic [15:0] rd; int lat; int ces; logic wes;
    mem_access(1'b1, 16'h3000, 16'h1234, 0, 8'h00, rd, lat, ces, wes);
    tests_run++;
    if (lat !== 3 || ces !== 1 || wes !== 1'b1) begin
      tests_failed++;
      $display("FAIL sram_write_seq: got lat=%0d ce=%0d we=%b want lat=3 ce=1 we=1", lat, ces, wes);
    end
    tests_run++;
    if (sram_mem[16'h3000] !== 16'h1234) begin
      tests_failed++; $display("FAIL sram_write_data: got %h want 1234", sram_mem[16'h3000]);
    end
    mem_access(1'b0, 16'h3000, 16'h0000, 0, 8'h00, rd, lat, ces, wes);
    tests_run++;
    if (lat !== 3 || ces !== 1 || wes !== 1'b0 || rd !== 16'h1234) begin
      tests_failed++;
      $display("FAIL sram_read: got lat=%0d ce=%0d we=%b data=%h want 3 1 0 1234",
               lat, ces, wes, rd);
    end
  endtask

  task automatic test_kb_read();
    logic [15:0] rd; int lat; int ces; logic wes;
    kb_strobe(8'h41);
    mem_access(1'b0, 16'hFE00, 16'h0000, 0, 8'h00, rd, lat, ces, wes);
    tests_run++;
    if (rd !== 16'h8000 || lat !== 2 || ces !== 0) begin
      tests_failed++;
      $display("FAIL kbsr_ready: got %h lat=%0d ce=%0d want 8000 lat=2 ce=0", rd, lat, ces);
    end
    mem_access(1'b0, 16'hFE02, 16'h0000, 0, 8'h00, rd, lat, ces, wes);
    tests_run++;
    if (rd !== 16'h0041 || ces !== 0) begin
      tests_failed++; $display("FAIL kbdr_read: got %h ce=%0d want 0041 ce=0", rd, ces);
    end
    mem_access(1'b0, 16'hFE00, 16'h0000, 0, 8'h00, rd, lat, ces, wes);
    tests_run++;
    if (rd !== 16'h0000) begin
      tests_failed++; $display("FAIL kbsr_cleared: got %h want 0000", rd);
    end
  endtask

  task automatic test_unmapped();
    logic [15:0] rd; int lat; int ces; logic wes;
    mem_access(1'b0, 16'hFE08, 16'h0000, 0, 8'h00, rd, lat, ces, wes);
    tests_run++;
    if (rd !== 16'h0000 || lat !== 2 || ces !== 0) begin
      tests_failed++; $display("FAIL unmapped_fe08: got %h lat=%0d ce=%0d want 0 2 0", rd, lat, ces);
    end
    mem_access(1'b1, 16'hFFFF, 16'h5555, 0, 8'h00, rd, lat, ces, wes);
    mem_access(1'b0, 16'hFFFF, 16'h0000, 0, 8'h00, rd, lat, ces, wes);
    tests_run++;
    if (rd !== 16'h0000 || lat !== 2 || ces !== 0) begin
      tests_failed++; $display("FAIL unmapped_ffff: got %h lat=%0d ce=%0d want 0 2 0", rd, lat, ces);
    end
    mem_access(1'b1, 16'hFDFE, 16'h0BEE, 0, 8'h00, rd, lat, ces, wes);
    mem_access(1'b0, 16'hFDFE, 16'h0000, 0, 8'h00, rd, lat, ces, wes);
    tests_run++;
    if (rd !== 16'h0BEE || lat !== 3 || ces !== 1) begin
      tests_failed++; $display("FAIL sram_fdfe: got %h lat=%0d ce=%0d want 0bee 3 1", rd, lat, ces);
    end
  endtask

  task automatic test_kb_int();
    logic [15:0] rd; int lat; int ces; logic wes;
    mem_access(1'b1, 16'hFE00, 16'h4000, 0, 8'h00, rd, lat, ces, wes);
    tests_run++;
    if (INT !== 1'b0) begin
      tests_failed++; $display("FAIL int_ie_only: got %b want 0", INT);
    end
    kb_strobe(8'h0D);
    tests_run++;
    if ({INT, int_vector, int_priority} !== {1'b1, 8'h80, 3'd4}) begin
      tests_failed++;
      $display("FAIL kb_int: got %b %h %0d want 1 80 4", INT, int_vector, int_priority);
    end
    mem_access(1'b0, 16'hFE02, 16'h0000, 0, 8'h00, rd, lat, ces, wes);
    tests_run++;
    if (rd !== 16'h000D || {INT, int_vector, int_priority} !== 12'h000) begin
      tests_failed++;
      $display("FAIL kb_int_clear: got %h %b %h %0d want 000d 0 00 0",
               rd, INT, int_vector, int_priority);
    end
    mem_access(1'b1, 16'hFE00, 16'hC000, 0, 8'h00, rd, lat, ces, wes);
    mem_access(1'b0, 16'hFE00, 16'h0000, 0, 8'h00, rd, lat, ces, wes);
    tests_run++;
    if (rd !== 16'h4000) begin
      tests_failed++; $display("FAIL kbsr_ro_ready: got %h want 4000", rd);
    end
    mem_access(1'b1, 16'hFE00, 16'h0000, 0, 8'h00, rd, lat, ces, wes);
  endtask

  task automatic test_display();
    logic [15:0] rd; int lat; int ces; logic wes;
    logic [15:0] exp_dsr;
    logic        exp_int;
    mem_access(1'b1, 16'hFE06, 16'h0048, 0, 8'h00, rd, lat, ces, wes);
    tests_run++;
    if ({disp_valid, disp_data} !== {1'b1, 8'h48} || lat !== 2 || ces !== 0) begin
      tests_failed++;
      $display("FAIL ddr_write: got v=%b d=%h lat=%0d ce=%0d want 1 48 2 0",
               disp_valid, disp_data, lat, ces);
    end
    mem_access(1'b1, 16'hFE06, 16'h0055, 0, 8'h00, rd, lat, ces, wes);
    mem_access(1'b0, 16'hFE04, 16'h0000, 0, 8'h00, rd, lat, ces, wes);
    tests_run++;
    if (disp_data !== 8'h48 || rd !== 16'h0000) begin
      tests_failed++; $display("FAIL ddr_drop: got d=%h dsr=%h want 48 0000", disp_data, rd);
    end
    ack_pulse();
    mem_access(1'b0, 16'hFE04, 16'h0000, 0, 8'h00, rd, lat, ces, wes);
    tests_run++;
    if (disp_valid !== 1'b0 || rd !== 16'h8000) begin
      tests_failed++; $display("FAIL disp_ack: got v=%b dsr=%h want 0 8000", disp_valid, rd);
    end
    mem_access(1'b1, 16'hFE06, 16'h0049, 0, 8'h00, rd, lat, ces, wes);
    mem_access(1'b1, 16'hFE06, 16'h005A, 2, 8'h00, rd, lat, ces, wes);
    tests_run++;
    if ({disp_valid, disp_data} !== {1'b1, 8'h5A}) begin
      tests_failed++;
      $display("FAIL ddr_with_ack: got v=%b d=%h want 1 5a", disp_valid, disp_data);
    end
    ack_pulse();
    mem_access(1'b1, 16'hFE04, 16'h4000, 0, 8'h00, rd, lat, ces, wes);
    mem_access(1'b0, 16'hFE04, 16'h0000, 0, 8'h00, rd, lat, ces, wes);
`ifdef LC3_DISP_INT_EN
    exp_dsr = 16'hC000; exp_int = 1'b1;
`else
    exp_dsr = 16'h8000; exp_int = 1'b0;
`endif
    tests_run++;
    if (rd !== exp_dsr || INT !== exp_int) begin
      tests_failed++;
      $display("FAIL dsr_ie: got dsr=%h int=%b want %h %b", rd, INT, exp_dsr, exp_int);
    end
    mem_access(1'b1, 16'hFE04, 16'h0000, 0, 8'h00, rd, lat, ces, wes);
  endtask

  task automatic test_back_to_back();
    logic [5:0] obs;
    int ces;
    obs = '0; ces = 0;
    @(negedge clk);
    memEN = 1'b1; memWE = 1'b0; mar = 16'hFE00;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      obs[i] = memRDY;
      if (sram_ce) ces++;
      if (i == 4) memEN = 1'b0;
    end
    tests_run++;
    if (obs !== 6'b010010 || ces !== 0) begin
      tests_failed++; $display("FAIL back_to_back: got %b ce=%0d want 010010 ce=0", obs, ces);
    end
  endtask

  task automatic test_reset_mid_access();
    logic [15:0] rd; int lat; int ces; logic wes;
    logic [71:0] outs;
    int rdy_cnt;
    mem_access(1'b1, 16'hFE00, 16'h4000, 0, 8'h00, rd, lat, ces, wes);
    kb_strobe(8'h55);
    mem_access(1'b1, 16'hFE06, 16'h0077, 0, 8'h00, rd, lat, ces, wes);
    mem_access(1'b0, 16'h3000, 16'h0000, 0, 8'h00, rd, lat, ces, wes);
    tests_run++;
    if (INT !== 1'b1 || disp_valid !== 1'b1 || rd_data !== 16'h1234) begin
      tests_failed++;
      $display("FAIL pre_reset_state: got int=%b v=%b rd=%h want 1 1 1234",
               INT, disp_valid, rd_data);
    end
    @(negedge clk);
    memEN = 1'b1; memWE = 1'b0; mar = 16'h3000;
    @(posedge clk); #1;
    rst = 1'b1; memEN = 1'b0;
    @(posedge clk); #1;
    outs = {rd_data, memRDY, sram_ce, sram_we, sram_addr, sram_wdata, disp_valid, disp_data,
            INT, int_vector, int_priority};
    tests_run++;
    if (outs !== '0) begin
      tests_failed++; $display("FAIL reset_mid_outputs: got %h want 0", outs);
    end
    rst = 1'b0;
    rdy_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (memRDY) rdy_cnt++;
    end
    tests_run++;
    if (rdy_cnt !== 0) begin
      tests_failed++; $display("FAIL reset_no_rdy: got %0d pulses want 0", rdy_cnt);
    end
    mem_access(1'b0, 16'hFE02, 16'h0000, 0, 8'h00, rd, lat, ces, wes);
    tests_run++;
    if (rd !== 16'h0000) begin
      tests_failed++; $display("FAIL reset_kbdr: got %h want 0000", rd);
    end
    mem_access(1'b0, 16'h3000, 16'h0000, 0, 8'h00, rd, lat, ces, wes);
    tests_run++;
    if (rd !== 16'h1234 || lat !== 3 || ces !== 1) begin
      tests_failed++;
      $display("FAIL read_after_reset: got %h lat=%0d ce=%0d want 1234 3 1", rd, lat, ces);
    end
  endtask

  task automatic test_kb_overrun();
    logic [15:0] rd; int lat; int ces; logic wes;
    kb_strobe(8'h41);
    kb_strobe(8'h42);
    mem_access(1'b0, 16'hFE02, 16'h0000, 1, 8'h43, rd, lat, ces, wes);
    tests_run++;
    if (rd !== 16'h0041) begin
      tests_failed++; $display("FAIL kb_overrun_old: got %h want 0041", rd);
    end
    mem_access(1'b0, 16'hFE00, 16'h0000, 0, 8'h00, rd, lat, ces, wes);
    tests_run++;
    if (rd !== 16'h8000) begin
      tests_failed++; $display("FAIL kb_ready_kept: got %h want 8000", rd);
    end
    mem_access(1'b0, 16'hFE02, 16'h0000, 0, 8'h00, rd, lat, ces, wes);
    tests_run++;
    if (rd !== 16'h0043) begin
      tests_failed++; $display("FAIL kb_simul_load: got %h want 0043", rd);
    end
    mem_access(1'b0, 16'hFE00, 16'h0000, 0, 8'h00, rd, lat, ces, wes);
    tests_run++;
    if (rd !== 16'h0000) begin
      tests_failed++; $display("FAIL kb_final_clear: got %h want 0000", rd);
    end
  endtask

  initial begin
    test_reset();
    test_sram_rw();
    test_kb_read();
    test_unmapped();
    test_kb_int();
    test_display();
    test_back_to_back();
    test_reset_mid_access();
    test_kb_overrun();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
